storage_cell_bank: RTL and testbench

- Parametrised, fully synchronous successor to our single-instance flop/latch demo cells.
- Provides CHANNELS independent 1-bit storage channels. Each channel's mode is set at runtime: D flop, set/reset cell, C-element (majority hold), T flop, or JK flop.
- Each channel has a saturating transition counter that can be read back.
- Sits behind the io_in/io_out pin mux of a user module; all cell behaviour is clocked, with no combinational feedback loops.

---
 rtl/storage_cell_bank.sv | 110 +++++++++++
 tb/tb_storage_cell_bank.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/storage_cell_bank.sv
// rtl/storage_cell_bank.sv - bank of runtime-configurable clocked 1-bit storage cells with saturating transition counters; optional JK mode via STORAGE_CELL_BANK_JK_EN
module storage_cell_bank #(
    parameter int                  CHANNELS    = 4,
    parameter int                  CNT_W       = 8,
    parameter logic [CHANNELS-1:0] RST_VAL     = {CHANNELS{1'b0}},
    parameter bit                  SR_RST_PRIO = 1'b1,
    localparam int                 SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [SEL_W-1:0]    cfg_ch,
    input  logic [2:0]          cfg_mode,
    input  logic [CHANNELS-1:0] a,
    input  logic [CHANNELS-1:0] b,
    output logic [CHANNELS-1:0] q,
    output logic [CHANNELS-1:0] qn,
    input  logic [SEL_W-1:0]    rd_ch,
    input  logic                cnt_clr,
    output logic [CNT_W-1:0]    rd_cnt
);

    typedef enum logic [2:0] {
        MODE_DFF = 3'd0,
        MODE_SR  = 3'd1,
        MODE_CEL = 3'd2,
        MODE_TFF = 3'd3,
        MODE_JK  = 3'd4
    } mode_e;

    // Raw 3-bit mode per channel; values 5-7 (and 4 without JK) are hold.
    logic [2:0]          mode  [CHANNELS];
    logic [CNT_W-1:0]    cnt   [CHANNELS];
    logic [CHANNELS-1:0] q_nxt;

    assign qn = ~q;

    // Next-state of every cell from its current mode and sampled a/b.
    always_comb begin
        q_nxt = q;
        for (int i = 0; i < CHANNELS; i++) begin
            case (mode[i])
                MODE_DFF: begin
                    if (b[i]) q_nxt[i] = a[i];
                end
                MODE_SR: begin
                    if (a[i] && b[i])  q_nxt[i] = ~SR_RST_PRIO;
                    else if (a[i])     q_nxt[i] = 1'b1;
                    else if (b[i])     q_nxt[i] = 1'b0;
                end
                MODE_CEL: begin
                    if (a[i] == b[i]) q_nxt[i] = a[i];
                end
                MODE_TFF: begin
                    if (b[i])      q_nxt[i] = 1'b0;
                    else if (a[i]) q_nxt[i] = ~q[i];
                end
`ifdef STORAGE_CELL_BANK_JK_EN
                MODE_JK: begin
                    case ({a[i], b[i]})
                        2'b10:   q_nxt[i] = 1'b1;
                        2'b01:   q_nxt[i] = 1'b0;
                        2'b11:   q_nxt[i] = ~q[i];
                        default: q_nxt[i] = q[i];
                    endcase
                end
`endif
                default: q_nxt[i] = q[i];
            endcase
        end
    end

    // Cell state register; reset overrides every other update.
    always_ff @(posedge clk) begin
        if (reset) q <= RST_VAL;
        else       q <= q_nxt;
    end

    // Mode registers; the write edge itself still evaluates the old mode.
    // Out-of-range cfg_ch matches no channel and is therefore dropped.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (reset)
                mode[i] <= MODE_DFF;
            else if (cfg_we && (cfg_ch == SEL_W'(i)))
                mode[i] <= cfg_mode;
        end
    end

    // Saturating transition counters; a clear beats a same-edge transition.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (reset)
                cnt[i] <= '0;
            else if (cnt_clr && (rd_ch == SEL_W'(i)))
                cnt[i] <= '0;
            else if ((q_nxt[i] != q[i]) && (cnt[i] != {CNT_W{1'b1}}))
                cnt[i] <= cnt[i] + 1'b1;
        end
    end

    // Counter read mux; an out-of-range select reads zero.
    always_comb begin
        rd_cnt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_ch == SEL_W'(i)) rd_cnt = cnt[i];
        end
    end

endmodule

// File: tb/tb_storage_cell_bank.sv
// tb/tb_storage_cell_bank.sv - scoreboard bench for storage_cell_bank against a behavioural model
module tb_storage_cell_bank;

    localparam int       NCH     = 3;
    localparam int       CW      = 4;
    localparam bit [2:0] RSTV    = 3'b010;
    localparam bit       SR_PRIO = 1'b1;
    localparam int       CMAX    = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           cfg_we = 1'b0;
    logic [1:0]     cfg_ch = '0;
    logic [2:0]     cfg_mode = '0;
    logic [NCH-1:0] a = '0;
    logic [NCH-1:0] b = '0;
    logic [NCH-1:0] q;
    logic [NCH-1:0] qn;
    logic [1:0]     rd_ch = '0;
    logic           cnt_clr = 1'b0;
    logic [CW-1:0]  rd_cnt;

    storage_cell_bank #(
        .CHANNELS    (NCH),
        .CNT_W       (CW),
        .RST_VAL     (RSTV),
        .SR_RST_PRIO (SR_PRIO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_mode (cfg_mode),
        .a        (a),
        .b        (b),
        .q        (q),
        .qn       (qn),
        .rd_ch    (rd_ch),
        .cnt_clr  (cnt_clr),
        .rd_cnt   (rd_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    bit [NCH-1:0] exp_q_q[$];
    int           exp_cnt_q[$];
    int           exp_id_q[$];
    int           step_id = 0;

    bit [NCH-1:0] m_q;
    int           m_mode [NCH];
    int           m_cnt  [NCH];

    function automatic bit cell_next(int md, bit cur, bit ai, bit bi);
        case (md)
            0: return bi ? ai : cur;
            1: begin
                if (ai && bi) return !SR_PRIO;
                if (ai)       return 1'b1;
                if (bi)       return 1'b0;
                return cur;
            end
            2: return (ai == bi) ? ai : cur;
            3: begin
                if (bi) return 1'b0;
                if (ai) return !cur;
                return cur;
            end
`ifdef STORAGE_CELL_BANK_JK_EN
            4: begin
                if (ai && bi) return !cur;
                if (ai)       return 1'b1;
                if (bi)       return 1'b0;
                return cur;
            end
`endif
            default: return cur;
        endcase
    endfunction

    task automatic step(input bit rst, input bit we, input int ch, input int md,
                        input bit [NCH-1:0] av, input bit [NCH-1:0] bv,
                        input int rch, input bit clr);
        bit [NCH-1:0] nq;
        @(negedge clk);
        reset    = rst;
        cfg_we   = we;
        cfg_ch   = 2'(ch);
        cfg_mode = 3'(md);
        a        = av;
        b        = bv;
        rd_ch    = 2'(rch);
        cnt_clr  = clr;
        if (rst) begin
            m_q = RSTV;
            for (int i = 0; i < NCH; i++) begin
                m_mode[i] = 0;
                m_cnt[i]  = 0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) nq[i] = cell_next(m_mode[i], m_q[i], av[i], bv[i]);
            for (int i = 0; i < NCH; i++) begin
                if (clr && rch == i)   m_cnt[i] = 0;
                else if (nq[i] != m_q[i]) m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
            end
            m_q = nq;
            if (we && ch < NCH) m_mode[ch] = md;
        end
        step_id++;
        exp_q_q.push_back(m_q);
        exp_cnt_q.push_back((rch < NCH) ? m_cnt[rch] : 0);
        exp_id_q.push_back(step_id);
    endtask

    // Monitor: every edge that has a pending expectation is checked just after it.
    initial begin
        bit [NCH-1:0] eq;
        int           ec;
        int           id;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q_q.size() > 0) begin
                eq = exp_q_q.pop_front();
                ec = exp_cnt_q.pop_front();
                id = exp_id_q.pop_front();
                n_checks++;
                if (q === eq) n_pass++;
                else $display("FAIL q step %0d: got %b expected %b", id, q, eq);
                n_checks++;
                if (qn === ~eq) n_pass++;
                else $display("FAIL qn step %0d: got %b expected %b", id, qn, ~eq);
                n_checks++;
                if (rd_cnt === CW'(ec)) n_pass++;
                else $display("FAIL rd_cnt step %0d: got %0d expected %0d", id, rd_cnt, ec);
            end
        end
    end

    initial begin
        int wait_cyc;
        // Reset, then DFF on ch0: b=0 holds, b=1 loads.
        step(1, 0, 0, 0, 3'b000, 3'b000, 0, 0);
        step(0, 0, 0, 0, 3'b001, 3'b000, 0, 0);
        step(0, 0, 0, 0, 3'b001, 3'b001, 0, 0);
        // SR on ch1: write edge still behaves as DFF, then a=b=1.
        step(0, 1, 1, 1, 3'b010, 3'b000, 1, 0);
        step(0, 0, 0, 0, 3'b010, 3'b010, 1, 0);
        // C-element on ch2: 11,10,01,00,10.
        step(0, 1, 2, 2, 3'b000, 3'b000, 2, 0);
        step(0, 0, 0, 0, 3'b100, 3'b100, 2, 0);
        step(0, 0, 0, 0, 3'b100, 3'b000, 2, 0);
        step(0, 0, 0, 0, 3'b000, 3'b100, 2, 0);
        step(0, 0, 0, 0, 3'b000, 3'b000, 2, 0);
        step(0, 0, 0, 0, 3'b100, 3'b000, 2, 0);
        // TFF on ch0 toggling 20 edges into saturation, then clear while toggling.
        step(0, 1, 0, 3, 3'b000, 3'b000, 0, 0);
        for (int k = 0; k < 20; k++) step(0, 0, 0, 0, 3'b001, 3'b000, 0, 0);
        step(0, 0, 0, 0, 3'b001, 3'b000, 0, 1);
        step(0, 0, 0, 0, 3'b001, 3'b000, 0, 0);
        // Mode 4 on ch1: jk=10,11,11,01.
        step(0, 1, 1, 4, 3'b000, 3'b000, 1, 0);
        step(0, 0, 0, 0, 3'b010, 3'b000, 1, 0);
        step(0, 0, 0, 0, 3'b010, 3'b010, 1, 0);
        step(0, 0, 0, 0, 3'b010, 3'b010, 1, 0);
        step(0, 0, 0, 0, 3'b000, 3'b010, 1, 0);
        // Out-of-range config write and counter read/clear.
        step(0, 1, 3, 2, 3'b111, 3'b000, 3, 1);
        step(0, 0, 0, 0, 3'b111, 3'b000, 3, 0);
        step(0, 0, 0, 0, 3'b111, 3'b000, 0, 0);
        // Reset while ch0 toggles in TFF mode, then confirm DFF holds with b=0.
        step(0, 0, 0, 0, 3'b001, 3'b000, 0, 0);
        step(1, 0, 0, 0, 3'b001, 3'b000, 0, 0);
        step(0, 0, 0, 0, 3'b001, 3'b000, 0, 0);
        // Randomised traffic.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 20),
                 $urandom_range(0, 3),
                 $urandom_range(0, 7),
                 3'($urandom), 3'($urandom),
                 $urandom_range(0, 3),
                 ($urandom_range(0, 99) < 8));
        end
        @(negedge clk);
        reset = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
        wait_cyc = 0;
        while (exp_q_q.size() > 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (exp_q_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d pending expectations, required 0", exp_q_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
